// File: rtl/mac_operand_sequencer.sv
// Operand buffer that feeds a MAC: collects up to DEPTH (a,b) pairs, then on start
// clears the accumulator and streams one pair per clock, pulsing done at the end.
module mac_operand_sequencer #(
    parameter int OP_WIDTH  = 2,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [OP_WIDTH-1:0]  wr_a,
    input  logic [OP_WIDTH-1:0]  wr_b,
    output logic                 wr_ready,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] fill,
    output logic [OP_WIDTH-1:0]  mac_a,
    output logic [OP_WIDTH-1:0]  mac_b,
    output logic                 mac_run,
    output logic                 mac_clear
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    idx;
    logic [CNT_WIDTH-1:0]    n_pairs;
    logic [2*OP_WIDTH-1:0]   buf_mem [DEPTH];
    logic                    accept;
    logic [CNT_WIDTH-1:0]    eff_fill;

    // Handshake: a pair is taken on a rising edge where wr_en and wr_ready are both high.
    assign accept   = (state == S_IDLE) && wr_en && wr_ready;
    assign eff_fill = fill + CNT_WIDTH'(accept);

    // Buffer contents need no reset; only entries below fill are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[fill[AW-1:0]] <= {wr_a, wr_b};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            fill      <= '0;
            idx       <= '0;
            n_pairs   <= '0;
            wr_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_run   <= 1'b0;
            mac_clear <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    fill <= eff_fill;
                    if (start && (eff_fill != '0)) begin
                        state     <= S_CLEAR;
                        n_pairs   <= eff_fill;
                        busy      <= 1'b1;
                        wr_ready  <= 1'b0;
                        mac_clear <= 1'b1;
                    end else begin
                        wr_ready  <= (eff_fill < DEPTH_C);
                    end
                end
                S_CLEAR: begin
                    // First pair is presented straight out of CLEAR so STREAM lasts exactly N cycles.
                    state     <= S_STREAM;
                    mac_clear <= 1'b0;
                    mac_run   <= 1'b1;
                    {mac_a, mac_b} <= buf_mem[0];
                    idx       <= CNT_WIDTH'(1);
                end
                S_STREAM: begin
                    if (idx == n_pairs) begin
                        state   <= S_DONE;
                        mac_run <= 1'b0;
                        mac_a   <= '0;
                        mac_b   <= '0;
                        done    <= 1'b1;
                    end else begin
                        {mac_a, mac_b} <= buf_mem[idx[AW-1:0]];
                        idx     <= idx + CNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    fill     <= '0;
                    idx      <= '0;
                    wr_ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with a downstream MAC accumulator model
// and an expected-pair queue checked cycle by cycle during each stream.
module tb_mac_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_a;
    logic [1:0] wr_b;
    logic       wr_ready;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] fill;
    logic [1:0] mac_a;
    logic [1:0] mac_b;
    logic       mac_run;
    logic       mac_clear;

    int n_chk;
    int n_err;
    logic [3:0] exp_q[$];
    logic [7:0] acc;
    int clear_cnt;
    int run_cnt;
    int done_cnt;

    mac_operand_sequencer dut (
        .clk       (clk),
        .reset     (rst_n),
        .wr_en     (wr_en),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .wr_ready  (wr_ready),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fill      (fill),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_run   (mac_run),
        .mac_clear (mac_clear)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // downstream MAC model plus pulse counters
    initial begin
        acc = '0;
        clear_cnt = 0;
        run_cnt = 0;
        done_cnt = 0;
    end

    always @(posedge clk) begin
        if (mac_clear) acc = '0;
        else if (mac_run) acc = acc + 8'(mac_a) * 8'(mac_b);
        if (mac_clear) clear_cnt++;
        if (mac_run) run_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: one write request lasting one clock
    task automatic wr(input logic [1:0] a, input logic [1:0] b);
        wr_en = 1'b1;
        wr_a  = a;
        wr_b  = b;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // driver + lockstep checker: start, then verify CLEAR, N stream cycles, DONE, IDLE
    task automatic run_vector(input int n, input bit poke, input logic [7:0] exp_sum);
        logic [3:0] exp_pair;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        if (poke) begin
            wr_en = 1'b1;
            wr_a  = 2'd3;
            wr_b  = 2'd3;
            start = 1'b1;
        end
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("clr_mac_clear", 8'(mac_clear), 8'd1);
                chk("clr_mac_run", 8'(mac_run), 8'd0);
                chk("clr_busy", 8'(busy), 8'd1);
                chk("clr_wr_ready", 8'(wr_ready), 8'd0);
                chk("clr_ops", 8'({mac_a, mac_b}), 8'd0);
            end else if (c <= n + 1) begin
                exp_pair = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
                chk("run_mac_run", 8'(mac_run), 8'd1);
                chk("run_mac_clear", 8'(mac_clear), 8'd0);
                chk("run_pair", 8'({mac_a, mac_b}), 8'(exp_pair));
            end else if (c == n + 2) begin
                chk("done_pulse", 8'(done), 8'd1);
                chk("done_mac_run", 8'(mac_run), 8'd0);
                chk("done_ops", 8'({mac_a, mac_b}), 8'd0);
                chk("done_busy", 8'(busy), 8'd1);
                wr_en = 1'b0;
                start = 1'b0;
            end else begin
                chk("idle_done", 8'(done), 8'd0);
                chk("idle_busy", 8'(busy), 8'd0);
                chk("idle_wr_ready", 8'(wr_ready), 8'd1);
                chk("idle_fill", 8'(fill), 8'd0);
            end
        end
        chk("mac_sum", acc, exp_sum);
        chk("exp_q_drained", 8'(exp_q.size()), 8'd0);
    endtask

    int snap_clear;
    int snap_run;
    int snap_done;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_a  = '0;
        wr_b  = '0;
        start = 1'b0;

        // reset state
        #2;
        chk("rst_wr_ready", 8'(wr_ready), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_fill", 8'(fill), 8'd0);
        chk("rst_outs", 8'({done, mac_run, mac_clear, mac_a, mac_b}), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_wr_ready", 8'(wr_ready), 8'd1);

        // 1: four pairs, sum 16, exact timing
        wr(2'd1, 2'd1); exp_q.push_back(4'b0101);
        wr(2'd2, 2'd2); exp_q.push_back(4'b1010);
        wr(2'd3, 2'd3); exp_q.push_back(4'b1111);
        wr(2'd1, 2'd2); exp_q.push_back(4'b0110);
        @(negedge clk);
        chk("t1_fill", 8'(fill), 8'd4);
        run_vector(4, 1'b0, 8'd16);

        // 2: fifth write dropped when full
        wr(2'd0, 2'd3); exp_q.push_back(4'b0011);
        wr(2'd3, 2'd0); exp_q.push_back(4'b1100);
        wr(2'd2, 2'd1); exp_q.push_back(4'b1001);
        wr(2'd3, 2'd3); exp_q.push_back(4'b1111);
        @(negedge clk);
        chk("t2_fill_full", 8'(fill), 8'd4);
        chk("t2_wr_ready_low", 8'(wr_ready), 8'd0);
        wr(2'd1, 2'd1);
        @(negedge clk);
        chk("t2_fill_after_drop", 8'(fill), 8'd4);
        run_vector(4, 1'b0, 8'd11);

        // 3: start with empty buffer is ignored
        snap_clear = clear_cnt;
        snap_run   = run_cnt;
        snap_done  = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t3_busy", 8'(busy), 8'd0);
        end
        chk("t3_no_clear", 8'(clear_cnt - snap_clear), 8'd0);
        chk("t3_no_run", 8'(run_cnt - snap_run), 8'd0);
        chk("t3_no_done", 8'(done_cnt - snap_done), 8'd0);

        // 4: write and start in the same cycle
        wr(2'd1, 2'd1); exp_q.push_back(4'b0101);
        @(negedge clk);
        chk("t4_fill", 8'(fill), 8'd1);
        wr_en = 1'b1;
        wr_a  = 2'd3;
        wr_b  = 2'd2;
        exp_q.push_back(4'b1110);
        run_vector(2, 1'b0, 8'd7);

        // 5: asynchronous reset during second stream cycle
        wr(2'd2, 2'd2);
        wr(2'd3, 2'd1);
        wr(2'd1, 2'd3);
        snap_done = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_run_abort", 8'(mac_run), 8'd0);
        chk("t5_ops_abort", 8'({mac_a, mac_b}), 8'd0);
        chk("t5_fill_abort", 8'(fill), 8'd0);
        chk("t5_busy_abort", 8'(busy), 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_no_done", 8'(done_cnt - snap_done), 8'd0);
        rst_n = 1'b1;
        #1;
        chk("t5_wr_ready_pre", 8'(wr_ready), 8'd0);
        @(negedge clk);
        chk("t5_wr_ready_post", 8'(wr_ready), 8'd1);
        wr(2'd2, 2'd3); exp_q.push_back(4'b1011);
        run_vector(1, 1'b0, 8'd6);

        // 6: wr_en and start while busy are ignored
        wr(2'd3, 2'd1); exp_q.push_back(4'b1101);
        wr(2'd2, 2'd1); exp_q.push_back(4'b1001);
        run_vector(2, 1'b1, 8'd5);
        snap_clear = clear_cnt;
        repeat (3) @(negedge clk);
        chk("t6_stays_idle", 8'(busy), 8'd0);
        chk("t6_fill", 8'(fill), 8'd0);
        chk("t6_no_restart", 8'(clear_cnt - snap_clear), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
